// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the copperv control sequencer: FSM states, decoded
// instruction classes, datapath selects, trap causes and small decode helpers.
package control_sequencer_pkg;

  localparam int STATE_WIDTH        = 3;
  localparam int INST_TYPE_WIDTH    = 4;
  localparam int ALU_COMP_WIDTH     = 3;
  localparam int FUNCT_WIDTH        = 4;
  localparam int ALU_OP_WIDTH       = 4;
  localparam int RD_DIN_SEL_WIDTH   = 2;
  localparam int PC_NEXT_SEL_WIDTH  = 3;
  localparam int ALU_DIN1_SEL_WIDTH = 1;
  localparam int ALU_DIN2_SEL_WIDTH = 2;

  // Bit positions inside alu_comp.
  localparam int ALU_COMP_EQ  = 0;
  localparam int ALU_COMP_LT  = 1;
  localparam int ALU_COMP_LTU = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    STATE_RESET, STATE_FETCH, STATE_DECODE, STATE_EXEC, STATE_MEM, STATE_TRAP
  } state_e;

  typedef enum logic [INST_TYPE_WIDTH-1:0] {
    INST_TYPE_IMM, INST_TYPE_INT_IMM, INST_TYPE_INT_REG, INST_TYPE_BRANCH,
    INST_TYPE_LOAD, INST_TYPE_STORE, INST_TYPE_JAL, INST_TYPE_JALR,
    INST_TYPE_AUIPC, INST_TYPE_FENCE
  } inst_type_e;

  typedef enum logic [FUNCT_WIDTH-1:0] {
    FUNCT_ADD, FUNCT_SUB, FUNCT_SLL, FUNCT_SLT, FUNCT_SLTU, FUNCT_XOR,
    FUNCT_SRL, FUNCT_SRA, FUNCT_OR, FUNCT_AND,
    FUNCT_EQ, FUNCT_NEQ, FUNCT_LT, FUNCT_GTE, FUNCT_LTU, FUNCT_GTEU
  } funct_e;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_OP_NOP, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
    ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND
  } alu_op_e;

  typedef enum logic [RD_DIN_SEL_WIDTH-1:0] {
    RD_DIN_SEL_IMM, RD_DIN_SEL_ALU, RD_DIN_SEL_MEM
  } rd_din_sel_e;

  typedef enum logic [PC_NEXT_SEL_WIDTH-1:0] {
    PC_NEXT_SEL_STALL, PC_NEXT_SEL_INCR, PC_NEXT_SEL_ADD_IMM,
    PC_NEXT_SEL_ADD_RS1_IMM, PC_NEXT_SEL_TRAP
  } pc_next_sel_e;

  typedef enum logic [ALU_DIN1_SEL_WIDTH-1:0] {
    ALU_DIN1_SEL_RS1, ALU_DIN1_SEL_PC
  } alu_din1_sel_e;

  typedef enum logic [ALU_DIN2_SEL_WIDTH-1:0] {
    ALU_DIN2_SEL_IMM, ALU_DIN2_SEL_RS2, ALU_DIN2_SEL_FOUR
  } alu_din2_sel_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE, MEM_SIZE_HALF, MEM_SIZE_WORD, MEM_SIZE_RESERVED
  } mem_size_e;

  typedef enum logic [1:0] {
    TRAP_CAUSE_ILLEGAL, TRAP_CAUSE_MISALIGNED,
    TRAP_CAUSE_FETCH_TIMEOUT, TRAP_CAUSE_MEM_TIMEOUT
  } trap_cause_e;

  function automatic alu_op_e funct_to_alu_op(input funct_e funct);
    case (funct)
      FUNCT_ADD:  return ALU_OP_ADD;
      FUNCT_SUB:  return ALU_OP_SUB;
      FUNCT_SLL:  return ALU_OP_SLL;
      FUNCT_SLT:  return ALU_OP_SLT;
      FUNCT_SLTU: return ALU_OP_SLTU;
      FUNCT_XOR:  return ALU_OP_XOR;
      FUNCT_SRL:  return ALU_OP_SRL;
      FUNCT_SRA:  return ALU_OP_SRA;
      FUNCT_OR:   return ALU_OP_OR;
      FUNCT_AND:  return ALU_OP_AND;
      default:    return ALU_OP_NOP;
    endcase
  endfunction

  function automatic logic branch_taken(input funct_e funct,
                                        input logic [ALU_COMP_WIDTH-1:0] comp);
    case (funct)
      FUNCT_EQ:   return comp[ALU_COMP_EQ];
      FUNCT_NEQ:  return !comp[ALU_COMP_EQ];
      FUNCT_LT:   return comp[ALU_COMP_LT];
      FUNCT_GTE:  return !comp[ALU_COMP_LT];
      FUNCT_LTU:  return comp[ALU_COMP_LTU];
      FUNCT_GTEU: return !comp[ALU_COMP_LTU];
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lsb);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return lsb[0];
      MEM_SIZE_WORD: return lsb != 2'd0;
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Level-held request / response handshakes of the instruction and data buses.
interface control_sequencer_if;
  logic inst_req;
  logic inst_valid;
  logic load_req;
  logic store_req;
  logic data_valid;

  modport master (output inst_req, load_req, store_req, input inst_valid, data_valid);
  modport slave  (input inst_req, load_req, store_req, output inst_valid, data_valid);
endinterface

// File: rtl/control_sequencer_bus_timeout.sv
// Wait-cycle counter shared by FETCH and MEM; expired flags the cycle the
// count reaches TIMEOUT (never when TIMEOUT is 0).
module control_sequencer_bus_timeout #(
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its default before any branch so no path leaves it unassigned and infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + TO_WIDTH'(1);
  end

  // NOTE: flops use non-blocking assignments so every register samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == TO_WIDTH'(TIMEOUT));
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for copperv: datapath selects, bus request handshakes,
// trap entry with cause, retire pulse and cycle/instret performance counters.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 32,
  parameter int TO_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  control_sequencer_if.master       bus,
  input  inst_type_e                inst_type,
  input  logic                      inst_illegal,
  input  logic [ALU_COMP_WIDTH-1:0] alu_comp,
  input  funct_e                    funct,
  input  mem_size_e                 mem_size,
  input  logic [1:0]                addr_lsb,
  output logic                      rd_en,
  output logic                      rs1_en,
  output logic                      rs2_en,
  output rd_din_sel_e               rd_din_sel,
  output pc_next_sel_e              pc_next_sel,
  output alu_din1_sel_e             alu_din1_sel,
  output alu_din2_sel_e             alu_din2_sel,
  output alu_op_e                   alu_op,
  output logic                      retire,
  output logic                      trap,
  output trap_cause_e               trap_cause,
  output logic [CNT_WIDTH-1:0]      cycle_cnt,
  output logic [CNT_WIDTH-1:0]      instret_cnt
);
  state_e               state_q, state_d;
  trap_cause_e          trap_cause_q, trap_cause_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] instret_cnt_q, instret_cnt_d;
  logic                 to_clear, to_enable, to_expired;
  logic                 is_store;

  assign is_store = (inst_type == INST_TYPE_STORE);

  // Every state change restarts the wait count, so entering FETCH or MEM always starts at zero.
  assign to_clear  = (state_d != state_q);
  assign to_enable = ((state_q == STATE_FETCH) && !bus.inst_valid) ||
                     ((state_q == STATE_MEM)   && !bus.data_valid);

  control_sequencer_bus_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_WIDTH(TO_WIDTH)
  ) u_bus_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_comb begin
    state_d       = state_q;
    trap_cause_d  = trap_cause_q;
    bus.inst_req  = 1'b0;
    bus.load_req  = 1'b0;
    bus.store_req = 1'b0;
    rd_en         = 1'b0;
    rs1_en        = 1'b0;
    rs2_en        = 1'b0;
    rd_din_sel    = RD_DIN_SEL_IMM;
    pc_next_sel   = PC_NEXT_SEL_STALL;
    alu_din1_sel  = ALU_DIN1_SEL_RS1;
    alu_din2_sel  = ALU_DIN2_SEL_IMM;
    alu_op        = ALU_OP_NOP;
    retire        = 1'b0;
    trap          = 1'b0;
    case (state_q)
      STATE_RESET: state_d = STATE_FETCH;
      STATE_FETCH: begin
        bus.inst_req = 1'b1;
        if (bus.inst_valid) begin
          if (inst_illegal) begin
            state_d      = STATE_TRAP;
            trap_cause_d = TRAP_CAUSE_ILLEGAL;
          end else if (inst_type == INST_TYPE_JAL) begin
            state_d = STATE_EXEC;
          end else begin
            state_d = STATE_DECODE;
          end
        end else if (to_expired) begin
          state_d      = STATE_TRAP;
          trap_cause_d = TRAP_CAUSE_FETCH_TIMEOUT;
        end
      end
      STATE_DECODE: begin
        state_d = STATE_EXEC;
        case (inst_type)
          INST_TYPE_IMM: begin
            rd_en       = 1'b1;
            pc_next_sel = PC_NEXT_SEL_INCR;
            retire      = 1'b1;
            state_d     = STATE_FETCH;
          end
          INST_TYPE_FENCE: begin
            pc_next_sel = PC_NEXT_SEL_INCR;
            retire      = 1'b1;
            state_d     = STATE_FETCH;
          end
          INST_TYPE_INT_IMM, INST_TYPE_LOAD, INST_TYPE_JALR: rs1_en = 1'b1;
          INST_TYPE_INT_REG, INST_TYPE_BRANCH, INST_TYPE_STORE: begin
            rs1_en = 1'b1;
            rs2_en = 1'b1;
          end
          default: ;
        endcase
      end
      STATE_EXEC: begin
        state_d = STATE_FETCH;
        case (inst_type)
          INST_TYPE_INT_IMM, INST_TYPE_INT_REG: begin
            rd_en        = 1'b1;
            rd_din_sel   = RD_DIN_SEL_ALU;
            alu_din2_sel = (inst_type == INST_TYPE_INT_REG) ? ALU_DIN2_SEL_RS2 : ALU_DIN2_SEL_IMM;
            alu_op       = funct_to_alu_op(funct);
            pc_next_sel  = PC_NEXT_SEL_INCR;
            retire       = 1'b1;
          end
          INST_TYPE_BRANCH: begin
            alu_din2_sel = ALU_DIN2_SEL_RS2;
            pc_next_sel  = branch_taken(funct, alu_comp) ? PC_NEXT_SEL_ADD_IMM : PC_NEXT_SEL_INCR;
            retire       = 1'b1;
          end
          INST_TYPE_JAL, INST_TYPE_JALR: begin
            rd_en        = 1'b1;
            rd_din_sel   = RD_DIN_SEL_ALU;
            alu_din1_sel = ALU_DIN1_SEL_PC;
            alu_din2_sel = ALU_DIN2_SEL_FOUR;
            alu_op       = ALU_OP_ADD;
            pc_next_sel  = (inst_type == INST_TYPE_JAL) ? PC_NEXT_SEL_ADD_IMM : PC_NEXT_SEL_ADD_RS1_IMM;
            retire       = 1'b1;
          end
          INST_TYPE_AUIPC: begin
            rd_en        = 1'b1;
            rd_din_sel   = RD_DIN_SEL_ALU;
            alu_din1_sel = ALU_DIN1_SEL_PC;
            alu_op       = ALU_OP_ADD;
            pc_next_sel  = PC_NEXT_SEL_INCR;
            retire       = 1'b1;
          end
          INST_TYPE_LOAD, INST_TYPE_STORE: begin
            alu_op = ALU_OP_ADD;
            if (is_misaligned(mem_size, addr_lsb)) begin
              state_d      = STATE_TRAP;
              trap_cause_d = TRAP_CAUSE_MISALIGNED;
            end else begin
              state_d = STATE_MEM;
            end
          end
          default: ;
        endcase
      end
      STATE_MEM: begin
        bus.load_req  = !is_store;
        bus.store_req = is_store;
        if (bus.data_valid) begin
          pc_next_sel = PC_NEXT_SEL_INCR;
          retire      = 1'b1;
          rd_en       = !is_store;
          rd_din_sel  = is_store ? RD_DIN_SEL_IMM : RD_DIN_SEL_MEM;
          state_d     = STATE_FETCH;
        end else if (to_expired) begin
          state_d      = STATE_TRAP;
          trap_cause_d = TRAP_CAUSE_MEM_TIMEOUT;
        end
      end
      STATE_TRAP: begin
        trap        = 1'b1;
        pc_next_sel = PC_NEXT_SEL_TRAP;
        state_d     = STATE_FETCH;
      end
      default: state_d = STATE_RESET;
    endcase
  end

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + CNT_WIDTH'(1);
    instret_cnt_d = instret_cnt_q + CNT_WIDTH'(retire);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= STATE_RESET;
      trap_cause_q  <= TRAP_CAUSE_ILLEGAL;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      trap_cause_q  <= trap_cause_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign trap_cause  = trap_cause_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
endmodule
